// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and constants for the fetch/LSU memory arbiter:
//            FSM state encodings, port ids and grant-vector bit positions.
//            Supplies a fallback `ADDR_WIDTH when the system header is absent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Bit positions inside the selector's grant vector
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
// ============================================================================
// Module   : arb_pick
// Brief    : Combinational request selector for the memory arbiter.
//            MEM_ARB_RR_EN defined   : round-robin on conflict (opposite of
//                                      the last grant).
//            MEM_ARB_RR_EN undefined : fixed priority, data port wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // Conflict goes to whichever port did not win the previous grant.
  always_comb begin
    grant = 2'b00;
    if (i_req && d_req) begin
      if (last_grant == PORT_D) begin
        grant[GNT_I] = 1'b1;
      end else begin
        grant[GNT_D] = 1'b1;
      end
    end else begin
      grant[GNT_I] = i_req;
      grant[GNT_D] = d_req;
    end
  end
`else
  // History is irrelevant in the fixed-priority build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data port always wins a conflict; fetch only goes when LSU is quiet.
  always_comb begin
    grant        = 2'b00;
    grant[GNT_D] = d_req;
    grant[GNT_I] = i_req & ~d_req;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares the single-port main memory between instruction fetch
//            (port I) and load/store (port D). One transaction at a time:
//            IDLE (grant) -> ISSUE (drive memory) -> RESP (return result).
//            Optional build macro MEM_ARB_RR_EN selects round-robin
//            arbitration and adds the last-grant register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  // fetch port
  input  logic                   i_req,
  input  logic [`ADDR_WIDTH-1:0] i_addr,
  output logic                   i_gnt,
  output logic                   i_rvalid,
  output logic [DATA_WIDTH-1:0]  i_rdata,
  // load/store port
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [`ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]  d_wdata,
  output logic                   d_gnt,
  output logic                   d_done,
  output logic [DATA_WIDTH-1:0]  d_rdata,
  // memory port
  output logic                   mem_req_valid,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   mem_wdata_oe,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   busy
);

  arb_state_e             state_q, state_d;
  logic                   port_q, port_d;
  logic                   we_q, we_d;
  logic [`ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   busy_q, busy_d;

  logic       last_grant;
  logic [1:0] grant;
  logic       idle;
  logic       take;
  logic       in_issue;
  logic       in_resp;

  // Grants are suppressed while reset is held so every output reads 0.
  assign idle = (state_q == ARB_IDLE) && !reset;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign i_gnt = idle & grant[GNT_I];
  assign d_gnt = idle & grant[GNT_D];
  assign take  = i_gnt | d_gnt;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Remember the winner of every grant for the next conflict.
  always_comb begin
    last_grant_d = last_grant_q;
    if (take) begin
      last_grant_d = d_gnt ? PORT_D : PORT_I;
    end
  end

  // Last-grant history register; starts as if port D won most recently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_D;
`endif

  // Next-state and request latching; payload is captured only on a grant.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (take) begin
          state_d = ARB_ISSUE;
          port_d  = d_gnt ? PORT_D : PORT_I;
          we_d    = d_gnt & d_we;
          addr_d  = d_gnt ? d_addr : i_addr;
          wdata_d = d_gnt ? d_wdata : '0;
        end
      end
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and request latches; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign in_issue = (state_q == ARB_ISSUE);
  assign in_resp  = (state_q == ARB_RESP);

  // Output decode: memory port only in ISSUE, responses only in RESP.
  always_comb begin
    mem_req_valid = in_issue;
    mem_we        = in_issue & we_q;
    mem_wdata_oe  = in_issue & we_q;
    mem_addr      = in_issue ? addr_q  : '0;
    mem_wdata     = in_issue ? wdata_q : '0;
    i_rvalid      = in_resp & (port_q == PORT_I);
    d_done        = in_resp & (port_q == PORT_D);
    i_rdata       = i_rvalid ? mem_rdata : '0;
    d_rdata       = d_done   ? mem_rdata : '0;
  end

  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a synchronous
//            memory model and a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = `ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req_valid, mem_we, mem_wdata_oe, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input logic [5:0] a);
    if (a == 6'd3) return 32'h00000e13;
    return {16'hA5A5, 10'd0, a};
  endfunction

  // Synchronous memory: samples at the end of the request cycle.
  logic [DW-1:0] mem [0:63];
  logic [63:0]   mem_written = '0;
  logic [DW-1:0] mem_rdata_q = '0;
  always @(posedge clk) begin
    if (mem_req_valid) begin
      if (mem_we) begin
        mem[mem_addr[5:0]]         <= mem_wdata;
        mem_written[mem_addr[5:0]] <= 1'b1;
      end else begin
        mem_rdata_q <= mem_written[mem_addr[5:0]] ? mem[mem_addr[5:0]]
                                                  : init_word(mem_addr[5:0]);
      end
    end
  end
  assign mem_rdata = mem_rdata_q;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] data;
    int            due;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] ref_mem [0:63];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic          last_m;
  logic          saw_i, saw_d;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle observation of every DUT output against the scoreboard.
  task automatic monitor();
    logic exp_busy, exp_ig, exp_dg;
    txn_t t;
    cyc++;
    if (reset) begin
      sb.delete();
      last_m = PORT_D;
      saw_i  = 1'b0;
      saw_d  = 1'b0;
      chk("reset_outputs", {i_gnt, i_rvalid, i_rdata, d_gnt, d_done, d_rdata,
          mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wdata_oe, busy}, '0);
      return;
    end
    exp_busy = (sb.size() > 0) && (sb[0].due == cyc || sb[0].due == cyc + 1);
    chk("busy", busy, exp_busy);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      t = sb.pop_front();
      chk("i_rvalid", i_rvalid, t.port == PORT_I);
      chk("d_done", d_done, t.port == PORT_D);
      if (t.port == PORT_I) chk("i_rdata", i_rdata, t.data);
      else if (!t.we)       chk("d_rdata", d_rdata, t.data);
    end else begin
      chk("no_resp", {i_rvalid, d_done}, '0);
    end
    if (sb.size() > 0 && sb[0].due == cyc + 1) begin
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_we", mem_we, sb[0].we);
      chk("mem_wdata_oe", mem_wdata_oe, sb[0].we);
      chk("mem_addr", mem_addr, sb[0].addr);
      chk("mem_wdata", mem_wdata, sb[0].wd);
    end else begin
      chk("mem_quiet", {mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wdata_oe}, '0);
    end
    exp_ig = 1'b0;
    exp_dg = 1'b0;
    if (!exp_busy) begin
      if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
        if (last_m == PORT_D) exp_ig = 1'b1;
        else                  exp_dg = 1'b1;
`else
        exp_dg = 1'b1;
`endif
      end else begin
        exp_ig = i_req;
        exp_dg = d_req;
      end
    end
    chk("grant", {i_gnt, d_gnt}, {exp_ig, exp_dg});
    saw_i = i_gnt;
    saw_d = d_gnt;
    if (i_gnt) begin
      sb.push_back('{PORT_I, 1'b0, i_addr, '0, ref_mem[i_addr[5:0]], cyc + 2});
      last_m = PORT_I;
    end
    if (d_gnt) begin
      if (d_we) ref_mem[d_addr[5:0]] = d_wdata;
      sb.push_back('{PORT_D, d_we, d_addr, d_wdata,
                     d_we ? d_wdata : ref_mem[d_addr[5:0]], cyc + 2});
      last_m = PORT_D;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic is_d, input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_d ? saw_d : saw_i) && n < 20);
    chk({tag, "_gnt_seen"}, is_d ? saw_d : saw_i, 1'b1);
  endtask

  initial begin
    int   n;
    int   ig_count;
    logic [3:0] seq;
    int   k;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
    last_m = PORT_D;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Fetch only, word 3
    i_req = 1'b1; i_addr = AW'(3);
    wait_gnt(1'b0, "fetch", n);
    i_req = 1'b0;
    repeat (3) tick();

    // Store 0xDEADBEEF to 5; payload scrambled after grant
    d_req = 1'b1; d_we = 1'b1; d_addr = AW'(5); d_wdata = 32'hDEADBEEF;
    wait_gnt(1'b1, "store", n);
    d_req = 1'b0; d_addr = AW'(9); d_wdata = 32'h0;
    repeat (3) tick();

    // Load back from 5
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(5); d_wdata = 32'h00001234;
    wait_gnt(1'b1, "load", n);
    d_req = 1'b0;
    repeat (3) tick();

    // Request raised while busy: grant only in the next IDLE cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(3);
    wait_gnt(1'b1, "busy_first", n);
    d_addr = AW'(7);
    wait_gnt(1'b1, "busy_second", n);
    chk("busy_gnt_latency", n, 3);
    d_req = 1'b0;
    repeat (3) tick();

    // Reset in the ISSUE cycle abandons the fetch
    i_req = 1'b1; i_addr = AW'(4);
    wait_gnt(1'b0, "pre_reset", n);
    i_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Normal fetch after reset release
    i_req = 1'b1; i_addr = AW'(6);
    wait_gnt(1'b0, "post_reset", n);
    i_req = 1'b0;
    repeat (3) tick();

    // Conflict: both requesters held for four transactions
    i_req = 1'b1; i_addr = AW'(2);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(8);
    seq = '0; k = 0; ig_count = 0;
    repeat (12) begin
      tick();
      if ((saw_i || saw_d) && k < 4) begin
        seq[3 - k] = saw_d;
        k++;
      end
      if (saw_i) ig_count++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("conflict_grants", k, 4);
`ifdef MEM_ARB_RR_EN
    chk("conflict_order", seq, 4'b1010);
    chk("conflict_i_count", ig_count, 2);
`else
    chk("conflict_order", seq, 4'b1111);
    chk("conflict_i_count", ig_count, 0);
`endif
    repeat (3) tick();

    // Idle hold
    repeat (10) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
